bsg_axil_store_unpacker: RTL and testbench
==========================================

Name: bsg_axil_store_unpacker

Overview:
- Inverse of the AXI-lite store packer: consumes packed 32-bit commands {write_not_read, addr[22:0], data[7:0]} and issues single AXI-lite master transactions.
- Read data returns on a 32-bit valid/ready response stream.
- Sits at the far end of the packed command link and drives an AXI-lite slave (host CSR space or a memory window).
- One transaction outstanding at a time.

Parameters:
- axi_addr_width_p, 32, AXI-lite address width; must be >= 23.
- axi_data_width_p, 32, AXI-lite data width; fixed at 32.
- addr_base_p, 0, base OR'ed above the 23-bit packed address to form the AXI address; bits [22:0] must be zero.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset, asynchronous, active-low
- data_i  in  32  packed command {wnr[31], addr[30:8], byte[7:0]}
- v_i  in  1  command valid
- ready_o  out  1  command ready
- data_o  out  32  read response word
- v_o  out  1  response valid
- ready_i  in  1  response ready
- m_axi_awaddr_o  out  axi_addr_width_p  write address
- m_axi_awprot_o  out  3  fixed 3'b000
- m_axi_awvalid_o / m_axi_awready_i  out/in  1  AW handshake
- m_axi_wdata_o  out  32  write data
- m_axi_wstrb_o  out  4  write strobe
- m_axi_wvalid_o / m_axi_wready_i  out/in  1  W handshake
- m_axi_bresp_i  in  2  write response code
- m_axi_bvalid_i / m_axi_bready_o  in/out  1  B handshake
- m_axi_araddr_o  out  axi_addr_width_p  read address
- m_axi_arprot_o  out  3  fixed 3'b000
- m_axi_arvalid_o / m_axi_arready_i  out/in  1  AR handshake
- m_axi_rdata_i  in  32  read data
- m_axi_rresp_i  in  2  read response code
- m_axi_rvalid_i / m_axi_rready_o  in/out  1  R handshake

Behaviour:
- One clock; reset is asynchronous and active-low (reset_n_i). All state and output registers clear asynchronously on reset_n_i low. During reset every valid/ready output is 0 and data outputs are 0.
- Command acceptance:
  - ready_o=1 only in e_idle. On v_i&ready_o, register the command.
  - Address = addr_base_p | data_i[30:8], zero-extended.
  - wdata = the byte replicated 4x.
  - wstrb = 4'b0001 << addr[1:0].
- States:
  - e_idle: accept command → e_write if wnr=1, else e_read_addr.
  - e_write: awvalid and wvalid both asserted from the first cycle. Sticky aw_done/w_done flags record each handshake independently; a handshake may land in the same cycle or in either order. Each valid drops the cycle after its own handshake. When both are done → e_write_resp.
  - e_write_resp: bready=1. On bvalid → e_idle, or → e_ack when WRITE_ACK_EN.
  - e_read_addr: arvalid=1 until arready → e_read_data.
  - e_read_data: rready=1. On rvalid, capture rdata into the response register → e_resp.
  - e_resp: v_o=1, data_o=captured rdata, held stable until ready_i → e_idle.
- Latency, with a zero-wait slave:
  - Read: accept at cycle 0; AR at 1; R at 2; v_o at 3.
  - Write: accept at cycle 0; AW/W at 1; B at 2; idle and ready again at 3.
- Back-to-back: a new command is accepted only after return to e_idle. ready_o is registered-state based, so there is no combinational v_i→ready_o path.
- Error responses: nonzero rresp/bresp are not retried. Read data is returned as captured regardless of rresp.
- Backpressure on v_o never affects the AXI side, because rdata is already captured.
- Reset mid-transaction: the FSM returns to e_idle and the in-flight transaction is abandoned. Downstream AXI recovery is the integrator's responsibility.
- Unused command bits: none. Any write byte lane is legal.

Optional Feature:
- Macro: BSG_AXIL_STORE_UNPACKER_WRITE_ACK_EN.
- Defined: every completed write emits a response word {30'b0, bresp[1:0]} through e_ack (v_o=1 until ready_i). Upstream can count write completions and detect errors.
- Undefined: e_ack does not exist, writes produce no response, and bresp is discarded.

Test Plan:
- Read: data_i=32'h0012_3400, addr_base_p=32'h4000_0000 → araddr=32'h4000_1234; slave returns rdata=32'hDEAD_BEEF → data_o=32'hDEAD_BEEF with v_o held until ready_i.
- Write: data_i=32'h8000_02A5 → awaddr=base|0x2, wdata=32'hA5A5_A5A5, wstrb=4'b0100; one B accepted; no v_o without WRITE_ACK_EN.
- Write handshake ordering: wready 3 cycles before awready, then simultaneous, then awready first → exactly one AW and one W per command; valids drop the cycle after each handshake.
- Response backpressure: ready_i low for 10 cycles after read → data_o stable, ready_o=0, no new AR issued; ready_i high → idle next cycle, next command accepted.
- Async reset asserted while in e_read_data → all valids 0 immediately, before the next clock edge; after release, a fresh read completes normally.
- WRITE_ACK_EN defined, slave bresp=2'b10 → data_o=32'h0000_0002, v_o=1.

Source files
------------

// File: rtl/bsg_axil_store_unpacker.sv
// Unpacks 32-bit {wnr, addr[22:0], byte} commands into single AXI-lite master transactions.
// Optional macro BSG_AXIL_STORE_UNPACKER_WRITE_ACK_EN returns {30'b0, bresp} for each completed write.
module bsg_axil_store_unpacker #(
    parameter int axi_addr_width_p = 32,
    parameter int axi_data_width_p = 32,
    parameter logic [axi_addr_width_p-1:0] addr_base_p = '0
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,

    input  logic [31:0]                   data_i,
    input  logic                          v_i,
    output logic                          ready_o,

    output logic [31:0]                   data_o,
    output logic                          v_o,
    input  logic                          ready_i,

    output logic [axi_addr_width_p-1:0]   m_axi_awaddr_o,
    output logic [2:0]                    m_axi_awprot_o,
    output logic                          m_axi_awvalid_o,
    input  logic                          m_axi_awready_i,
    output logic [axi_data_width_p-1:0]   m_axi_wdata_o,
    output logic [axi_data_width_p/8-1:0] m_axi_wstrb_o,
    output logic                          m_axi_wvalid_o,
    input  logic                          m_axi_wready_i,
    input  logic [1:0]                    m_axi_bresp_i,
    input  logic                          m_axi_bvalid_i,
    output logic                          m_axi_bready_o,
    output logic [axi_addr_width_p-1:0]   m_axi_araddr_o,
    output logic [2:0]                    m_axi_arprot_o,
    output logic                          m_axi_arvalid_o,
    input  logic                          m_axi_arready_i,
    input  logic [axi_data_width_p-1:0]   m_axi_rdata_i,
    input  logic [1:0]                    m_axi_rresp_i,
    input  logic                          m_axi_rvalid_i,
    output logic                          m_axi_rready_o
);

    typedef enum logic [2:0] {
        e_idle,
        e_write,
        e_write_resp,
        e_read_addr,
        e_read_data,
        e_resp
`ifdef BSG_AXIL_STORE_UNPACKER_WRITE_ACK_EN
        , e_ack
`endif
    } state_e;

    state_e                              state_q, state_d;
    logic [axi_addr_width_p-1:0]         addr_q, addr_d;
    logic [7:0]                          byte_q, byte_d;
    logic [axi_data_width_p/8-1:0]       strb_q, strb_d;
    logic                                aw_done_q, aw_done_d;
    logic                                w_done_q, w_done_d;
    logic [31:0]                         resp_q, resp_d;
    // Holds ready_o low until the first clock after reset release.
    logic                                live_q;
    logic                                aw_hs, w_hs;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= e_idle;
            addr_q    <= '0;
            byte_q    <= '0;
            strb_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            resp_q    <= '0;
            live_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            byte_q    <= byte_d;
            strb_q    <= strb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            resp_q    <= resp_d;
            live_q    <= 1'b1;
        end
    end

    assign ready_o         = live_q && (state_q == e_idle);
    assign m_axi_awvalid_o = (state_q == e_write) && !aw_done_q;
    assign m_axi_wvalid_o  = (state_q == e_write) && !w_done_q;
    assign m_axi_bready_o  = (state_q == e_write_resp);
    assign m_axi_arvalid_o = (state_q == e_read_addr);
    assign m_axi_rready_o  = (state_q == e_read_data);
`ifdef BSG_AXIL_STORE_UNPACKER_WRITE_ACK_EN
    assign v_o             = (state_q == e_resp) || (state_q == e_ack);
`else
    assign v_o             = (state_q == e_resp);
`endif
    assign data_o          = resp_q;

    assign m_axi_awaddr_o  = addr_q;
    assign m_axi_araddr_o  = addr_q;
    assign m_axi_awprot_o  = 3'b000;
    assign m_axi_arprot_o  = 3'b000;
    assign m_axi_wdata_o   = axi_data_width_p'({4{byte_q}});
    assign m_axi_wstrb_o   = strb_q;

    assign aw_hs = m_axi_awvalid_o && m_axi_awready_i;
    assign w_hs  = m_axi_wvalid_o && m_axi_wready_i;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        byte_d    = byte_q;
        strb_d    = strb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        resp_d    = resp_q;
        case (state_q)
            e_idle: begin
                if (v_i && ready_o) begin
                    addr_d    = addr_base_p | axi_addr_width_p'(data_i[30:8]);
                    byte_d    = data_i[7:0];
                    strb_d    = (axi_data_width_p/8)'(4'b0001 << data_i[9:8]);
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = data_i[31] ? e_write : e_read_addr;
                end
            end
            e_write: begin
                // AW and W complete independently; move on once both have landed.
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = e_write_resp;
                end
            end
            e_write_resp: begin
                if (m_axi_bvalid_i) begin
`ifdef BSG_AXIL_STORE_UNPACKER_WRITE_ACK_EN
                    resp_d  = {30'b0, m_axi_bresp_i};
                    state_d = e_ack;
`else
                    state_d = e_idle;
`endif
                end
            end
            e_read_addr: begin
                if (m_axi_arready_i) state_d = e_read_data;
            end
            e_read_data: begin
                if (m_axi_rvalid_i) begin
                    resp_d  = 32'(m_axi_rdata_i);
                    state_d = e_resp;
                end
            end
            e_resp: begin
                if (ready_i) state_d = e_idle;
            end
`ifdef BSG_AXIL_STORE_UNPACKER_WRITE_ACK_EN
            e_ack: begin
                if (ready_i) state_d = e_idle;
            end
`endif
            default: state_d = e_idle;
        endcase
    end

    // Response codes are intentionally not acted on.
`ifdef BSG_AXIL_STORE_UNPACKER_WRITE_ACK_EN
    logic unused_resp;
    assign unused_resp = ^m_axi_rresp_i;
`else
    logic unused_resp;
    assign unused_resp = ^{m_axi_rresp_i, m_axi_bresp_i};
`endif

endmodule

// File: tb/tb_bsg_axil_store_unpacker.sv
// Directed bench for bsg_axil_store_unpacker: reads, writes, handshake ordering, backpressure, async reset.
module tb_bsg_axil_store_unpacker;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data_i = '0;
    logic        v_i = 1'b0;
    logic        ready_o;
    logic [31:0] data_o;
    logic        v_o;
    logic        ready_i = 1'b0;
    logic [31:0] awaddr, wdata, araddr, rdata = '0;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;

    int total = 0;
    int bad = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;

    bsg_axil_store_unpacker #(
        .axi_addr_width_p(32),
        .axi_data_width_p(32),
        .addr_base_p(BASE)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .data_i(data_i), .v_i(v_i), .ready_o(ready_o),
        .data_o(data_o), .v_o(v_o), .ready_i(ready_i),
        .m_axi_awaddr_o(awaddr), .m_axi_awprot_o(awprot),
        .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready),
        .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb),
        .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready),
        .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready),
        .m_axi_araddr_o(araddr), .m_axi_arprot_o(arprot),
        .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready),
        .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp),
        .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (awvalid && awready) aw_cnt++;
        if (wvalid && wready) w_cnt++;
        if (arvalid && arready) ar_cnt++;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({ready_o, v_o, awvalid, wvalid, bready, arvalid, rready} !== 7'b0) begin
            bad++; $display("FAIL reset_valids got=%b exp=0", {ready_o, v_o, awvalid, wvalid, bready, arvalid, rready});
        end
        total++;
        if ({data_o, awaddr, araddr, wdata, wstrb} !== '0) begin
            bad++; $display("FAIL reset_data got data_o=%h awaddr=%h wdata=%h exp=0", data_o, awaddr, wdata);
        end
        total++;
        if ({awprot, arprot} !== 6'b0) begin
            bad++; $display("FAIL prot got=%b exp=0", {awprot, arprot});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (ready_o !== 1'b1) begin
            bad++; $display("FAIL post_reset_ready got=%b exp=1", ready_o);
        end
    endtask

    // Zero-wait read; assumes we sit on a negedge in idle.
    task automatic do_read(input logic [31:0] cmd, input logic [31:0] exp_addr, input logic [31:0] rd);
        total++;
        if (ready_o !== 1'b1) begin
            bad++; $display("FAIL rd_ready got=%b exp=1", ready_o);
        end
        v_i = 1'b1; data_i = cmd;
        @(negedge clk);
        v_i = 1'b0;
        total++;
        if (arvalid !== 1'b1 || araddr !== exp_addr || ready_o !== 1'b0) begin
            bad++; $display("FAIL rd_ar got arvalid=%b araddr=%h ready_o=%b exp 1 %h 0", arvalid, araddr, ready_o, exp_addr);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        total++;
        if (arvalid !== 1'b0 || rready !== 1'b1) begin
            bad++; $display("FAIL rd_r got arvalid=%b rready=%b exp 0 1", arvalid, rready);
        end
        rvalid = 1'b1; rdata = rd;
        @(negedge clk);
        rvalid = 1'b0; rdata = '0;
        total++;
        if (v_o !== 1'b1 || data_o !== rd || rready !== 1'b0) begin
            bad++; $display("FAIL rd_resp got v_o=%b data_o=%h rready=%b exp 1 %h 0", v_o, data_o, rready, rd);
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        total++;
        if (v_o !== 1'b0 || ready_o !== 1'b1) begin
            bad++; $display("FAIL rd_done got v_o=%b ready_o=%b exp 0 1", v_o, ready_o);
        end
    endtask

    // Write with awready/wready pulsed aw_dly/w_dly cycles after the valids first rise.
    task automatic do_write(input logic [31:0] cmd, input int aw_dly, input int w_dly, input logic [1:0] br,
                            input logic [31:0] exp_addr, input logic [31:0] exp_wdata, input logic [3:0] exp_strb);
        int last;
        last = (aw_dly > w_dly) ? aw_dly : w_dly;
        aw_cnt = 0; w_cnt = 0;
        v_i = 1'b1; data_i = cmd;
        @(negedge clk);
        v_i = 1'b0;
        total++;
        if (awaddr !== exp_addr || wdata !== exp_wdata || wstrb !== exp_strb) begin
            bad++; $display("FAIL wr_fields got awaddr=%h wdata=%h wstrb=%b exp %h %h %b", awaddr, wdata, wstrb, exp_addr, exp_wdata, exp_strb);
        end
        for (int c = 0; c <= last; c++) begin
            total++;
            if (awvalid !== (c <= aw_dly) || wvalid !== (c <= w_dly) || bready !== 1'b0) begin
                bad++; $display("FAIL wr_valids c=%0d got aw=%b w=%b b=%b exp %b %b 0", c, awvalid, wvalid, bready, c <= aw_dly, c <= w_dly);
            end
            awready = (c == aw_dly);
            wready  = (c == w_dly);
            @(negedge clk);
        end
        awready = 1'b0; wready = 1'b0;
        total++;
        if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b1) begin
            bad++; $display("FAIL wr_bphase got aw=%b w=%b b=%b exp 0 0 1", awvalid, wvalid, bready);
        end
        bvalid = 1'b1; bresp = br;
        @(negedge clk);
        bvalid = 1'b0; bresp = 2'b00;
        total++;
        if (aw_cnt !== 1 || w_cnt !== 1) begin
            bad++; $display("FAIL wr_hs_count got aw=%0d w=%0d exp 1 1", aw_cnt, w_cnt);
        end
`ifdef BSG_AXIL_STORE_UNPACKER_WRITE_ACK_EN
        total++;
        if (v_o !== 1'b1 || data_o !== {30'b0, br} || bready !== 1'b0) begin
            bad++; $display("FAIL wr_ack got v_o=%b data_o=%h exp 1 %h", v_o, data_o, {30'b0, br});
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
`endif
        total++;
        if (v_o !== 1'b0 || ready_o !== 1'b1 || bready !== 1'b0) begin
            bad++; $display("FAIL wr_idle got v_o=%b ready_o=%b bready=%b exp 0 1 0", v_o, ready_o, bready);
        end
    endtask

    task automatic test_read();
        do_read(32'h0012_3400, 32'h4000_1234, 32'hDEAD_BEEF);
        do_read(32'h7FFF_FF00, 32'h407F_FFFF, 32'h0000_0001);
    endtask

    task automatic test_write();
        do_write(32'h8000_02A5, 0, 0, 2'b00, 32'h4000_0002, 32'hA5A5_A5A5, 4'b0100);
        do_write(32'hFFFF_FF3C, 0, 0, 2'b00, 32'h407F_FFFF, 32'h3C3C_3C3C, 4'b1000);
        do_write(32'h8000_0000, 0, 0, 2'b00, 32'h4000_0000, 32'h0000_0000, 4'b0001);
    endtask

    task automatic test_write_order();
        do_write(32'h8000_0111, 3, 0, 2'b00, 32'h4000_0001, 32'h1111_1111, 4'b0010);
        do_write(32'h8000_0122, 2, 2, 2'b00, 32'h4000_0001, 32'h2222_2222, 4'b0010);
        do_write(32'h8000_0333, 0, 2, 2'b00, 32'h4000_0003, 32'h3333_3333, 4'b1000);
    endtask

    task automatic test_write_ack();
        do_write(32'h8000_0455, 0, 0, 2'b10, 32'h4000_0004, 32'h5555_5555, 4'b0001);
    endtask

    task automatic test_backpressure();
        v_i = 1'b1; data_i = 32'h0000_0400;
        @(negedge clk);
        data_i = 32'h0000_0800;
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h1234_5678;
        @(negedge clk);
        rvalid = 1'b0; rdata = '0;
        ar_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (v_o !== 1'b1 || data_o !== 32'h1234_5678 || ready_o !== 1'b0 || arvalid !== 1'b0) begin
                bad++; $display("FAIL bp_hold i=%0d got v_o=%b data_o=%h ready_o=%b arvalid=%b", i, v_o, data_o, ready_o, arvalid);
            end
            @(negedge clk);
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        total++;
        if (ready_o !== 1'b1 || v_o !== 1'b0) begin
            bad++; $display("FAIL bp_release got ready_o=%b v_o=%b exp 1 0", ready_o, v_o);
        end
        @(negedge clk);
        v_i = 1'b0;
        total++;
        if (arvalid !== 1'b1 || araddr !== 32'h4000_0008 || ar_cnt !== 0) begin
            bad++; $display("FAIL bp_next got arvalid=%b araddr=%h ar_cnt=%0d exp 1 40000008 0", arvalid, araddr, ar_cnt);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hCAFE_F00D;
        @(negedge clk);
        rvalid = 1'b0; rdata = '0;
        total++;
        if (v_o !== 1'b1 || data_o !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL bp_next_resp got v_o=%b data_o=%h exp 1 cafef00d", v_o, data_o);
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
    endtask

    task automatic test_async_reset();
        v_i = 1'b1; data_i = 32'h0000_1000;
        @(negedge clk);
        v_i = 1'b0;
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        total++;
        if (rready !== 1'b1) begin
            bad++; $display("FAIL ar_pre got rready=%b exp 1", rready);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({ready_o, v_o, awvalid, wvalid, bready, arvalid, rready} !== 7'b0 || data_o !== 32'h0) begin
            bad++; $display("FAIL ar_async got=%b data_o=%h exp 0", {ready_o, v_o, awvalid, wvalid, bready, arvalid, rready}, data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_read(32'h0000_2200, 32'h4000_0022, 32'h5A5A_0F0F);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_write_order();
`ifdef BSG_AXIL_STORE_UNPACKER_WRITE_ACK_EN
        test_write_ack();
`endif
        test_backpressure();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
